// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the PUF serial path
package puf_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;
  localparam int CHAL_LEN = 128;
  function automatic int clog2_cnt(input int le);
    return $clog2(le + 1);
  endfunction
endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: loadable down-counter flagging the final bit (cnt==1)
module ser_bit_counter
  import puf_pkg::*;
#(
  parameter int le = CHAL_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic term
);
  localparam int CW = clog2_cnt(le);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= CW'(le);
    else if (dec && cnt != '0) cnt <= cnt - CW'(1);
  end
  assign term = (cnt == CW'(1));
endmodule

// File: rtl/puf_resp_serializer.sv
// puf_resp_serializer: handshaked parallel word to registered serial bit stream
module puf_resp_serializer
  import puf_pkg::*;
#(
  parameter int le = CHAL_LEN,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [le-1:0] par_in,
  input  logic          hold,
  output logic          ser_out,
  output logic          ser_en,
  output logic          last,
  output logic          busy
);
  ser_state_t state;
  logic [le-1:0] shadow;
  logic term;
  logic advance;
  assign load_ready = (state == IDLE);
  assign advance = (state == SHIFT) && !hold;
  ser_bit_counter #(.le(le)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(load_ready && load_valid),
    .dec (advance),
    .term(term)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load_valid) begin
          shadow <= par_in;
          busy   <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: if (!hold) begin
          ser_out <= MSB_FIRST ? shadow[le-1] : shadow[0];
          shadow  <= MSB_FIRST ? {shadow[le-2:0], 1'b0} : {1'b0, shadow[le-1:1]};
          ser_en  <= 1'b1;
          last    <= term;
          if (term) state <= DONE;
        end else begin
          ser_en <= 1'b0;
          last   <= 1'b0;
        end
        DONE: begin
          ser_en <= 1'b0;
          last   <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
